// File: rtl/hs_req_tx.sv
// Four-phase req/ack handshake transmitter with an internal ack synchronizer.
// Optional per-phase timeout with ABORT recovery when HS_TX_TIMEOUT_EN is defined.
module hs_req_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ack_async,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef HS_TX_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2,
    ABORT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_t;
`endif

  state_t               state_reg, state_next;
  logic [SYNC_STAGES-1:0] ack_sync_reg;
  logic                 ack_s;
  logic                 req_reg;
  logic                 done_reg, done_next;
  logic [WIDTH-1:0]     data_out_reg;
  logic                 load;

  // Flop chain for the asynchronous acknowledge; only the last stage is used.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) ack_sync_reg[gi] <= 1'b0;
          else     ack_sync_reg[gi] <= ack_async;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst) ack_sync_reg[gi] <= 1'b0;
          else     ack_sync_reg[gi] <= ack_sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign ack_s = ack_sync_reg[SYNC_STAGES-1];

`ifdef HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt_reg;
  logic          timeout_hit;
  logic          err_reg, err_next;

  assign timeout_hit = (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change, so each wait phase gets a fresh budget.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt_reg <= '0;
    else if (state_next != state_reg)
      tmo_cnt_reg <= '0;
    else if (state_reg == REQ_HI || state_reg == ACK_LO)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end
`endif

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    load       = 1'b0;
`ifdef HS_TX_TIMEOUT_EN
    err_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (send) begin
          state_next = REQ_HI;
          load       = 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_s)
          state_next = ACK_LO;
`ifdef HS_TX_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ABORT;
          err_next   = 1'b1;
        end
`endif
      end
      ACK_LO: begin
        if (!ack_s) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
`ifdef HS_TX_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ABORT;
          err_next   = 1'b1;
        end
`endif
      end
`ifdef HS_TX_TIMEOUT_EN
      // A late acknowledge must drain before the next transfer may start.
      ABORT: begin
        if (!ack_s)
          state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      done_reg     <= 1'b0;
      data_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= (state_next == REQ_HI);
      done_reg  <= done_next;
      if (load)
        data_out_reg <= data_in;
    end
  end

`ifdef HS_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= err_next;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign req      = req_reg;
  assign done     = done_reg;
  assign data_out = data_out_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_hs_req_tx.sv
// Bench for hs_req_tx: directed vector table, timeout sequence, and randomized
// run against a handshake-level reference model.
module tb_hs_req_tx;
  localparam int W = 8;
  localparam int S = 2;
  localparam int T = 16;
  localparam int NV = 36;

  logic         clk = 1'b0;
  logic         rst, send, ack_async;
  logic [W-1:0] data_in;
  logic         req, busy, done, err;
  logic [W-1:0] data_out;

  int errors = 0;
  int checks = 0;

  hs_req_tx #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .send(send), .data_in(data_in), .ack_async(ack_async),
    .req(req), .data_out(data_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         send;
    logic [W-1:0] din;
    logic         ack;
    logic         e_req;
    logic         e_busy;
    logic         e_done;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs[NV];

  // Reference model: transfer-level view (active, awaited ack level, aborting).
  logic         m_active, m_want, m_abort;
  int           m_wait;
  logic [W-1:0] m_data;
  logic         m_req, m_busy, m_done, m_err;
  logic         m_hist[S];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b need %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h need %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic e_busy,
                           input logic e_done, input logic e_err, input logic [W-1:0] e_data);
    chk1({tag, " req"}, req, e_req);
    chk1({tag, " busy"}, busy, e_busy);
    chk1({tag, " done"}, done, e_done);
    chk1({tag, " err"}, err, e_err);
    chk8({tag, " data_out"}, data_out, e_data);
  endtask

  task automatic model_step;
    logic acks;
    acks = m_hist[S-1];
    if (rst) begin
      m_active = 1'b0; m_want = 1'b0; m_abort = 1'b0; m_wait = 0;
      m_data = '0; m_done = 1'b0; m_err = 1'b0;
      for (int i = 0; i < S; i++) m_hist[i] = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!m_active) begin
        if (send) begin
          m_active = 1'b1; m_want = 1'b1; m_abort = 1'b0; m_wait = 0; m_data = data_in;
        end
      end else if (acks == m_want) begin
        if (m_want) begin
          m_want = 1'b0;
          m_wait = 0;
        end else begin
          m_active = 1'b0;
          m_done   = !m_abort;
          m_abort  = 1'b0;
        end
      end else begin
`ifdef HS_TX_TIMEOUT_EN
        if (!m_abort && m_wait == T - 1) begin
          m_err = 1'b1; m_abort = 1'b1; m_want = 1'b0;
        end else begin
          m_wait++;
        end
`endif
      end
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ack_async;
    end
    m_req  = m_active && m_want;
    m_busy = m_active;
  endtask

  initial begin
    // rst, send, din, ack | req, busy, done, data_out after the edge
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[11] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0F};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0F};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0F};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F};
    vecs[19] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55};
    vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55};
    vecs[24] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[28] = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 8'h66};
    vecs[29] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66};
    vecs[30] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66};
    vecs[31] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h66};
    vecs[32] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66};
    vecs[33] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66};
    vecs[34] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
    vecs[35] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66};

    rst = 1'b1; send = 1'b0; data_in = '0; ack_async = 1'b0;
    tick;
    tick;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Directed table: basic, ignored send, back-to-back, minimum latency, reset abort.
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; send = vecs[i].send; data_in = vecs[i].din; ack_async = vecs[i].ack;
      tick;
      check_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_busy, vecs[i].e_done,
                1'b0, vecs[i].e_data);
    end

    // Receiver never acknowledges.
    rst = 1'b0; send = 1'b1; data_in = 8'h99; ack_async = 1'b0;
    tick;
    send = 1'b0;
    check_out("tmo accept", 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
`ifdef HS_TX_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick;
      check_out($sformatf("tmo wait%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    end
    tick;
    check_out("tmo err", 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    tick;
    check_out("tmo idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
    for (int k = 0; k < 4; k++) begin
      tick;
      check_out("tmo after", 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      tick;
      check_out($sformatf("hang%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    end
`endif
    rst = 1'b1;
    tick;
    check_out("tmo reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Randomized run against the reference model.
    begin
      int stall;
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
        rst     = (i == 0) || ($urandom_range(0, 399) == 0);
        send    = ($urandom_range(0, 3) == 0);
        data_in = 8'($urandom);
        if (stall > 0) begin
          stall--;
        end else if ($urandom_range(0, 99) == 0) begin
          stall = $urandom_range(15, 30);
        end else if ($urandom_range(0, 3) == 0) begin
          ack_async = m_req;
        end else if ($urandom_range(0, 59) == 0) begin
          ack_async = ~ack_async;
        end
        model_step();
        tick;
        check_out($sformatf("rnd%0d", i), m_req, m_busy, m_done, m_err, m_data);
        if (m_done) $display("xfer cycle=%0d data=%h", i, m_data);
        if (m_err)  $display("abort cycle=%0d data=%h", i, m_data);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_req_tx.md
# hs_req_tx

Four-phase request/acknowledge handshake transmitter: the sending end of a clock-domain crossing whose receiving end captures our `req` through its own flop synchronizer. It latches a data word on `send` and holds it stable on `data_out`. It raises `req` and synchronizes the returning asynchronous `ack_async` internally. It completes the four-phase cycle and reports `done` to the local controller.

## Interface
- `WIDTH`, 8: width of the transferred data word.
- `SYNC_STAGES`, 2: flop stages on `ack_async`; legal range 2–4.
- `TIMEOUT_CYCLES`, 16: wait limit per handshake phase. Used only when `HS_TX_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `send` in 1: start request; sampled only in IDLE.
- `data_in` in WIDTH: word latched when `send` is accepted.
- `ack_async` in 1: acknowledge from the receiving domain; asynchronous to `clk`.
- `req` out 1: registered request to the receiving domain.
- `data_out` out WIDTH: latched word; stable from `req` rising until `done`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle timeout pulse. Tied 0 without `HS_TX_TIMEOUT_EN`.

## Operation
- Reset values, applied at a rising edge with `rst`=1: `req`=0, `data_out`=0, `busy`=0, `done`=0, `err`=0, state IDLE, all synchronizer flops 0, timeout counter 0. Reset mid-handshake aborts immediately with no `done` or `err`.
- `ack_s` is the output of the last `ack_async` synchronizer stage. The FSM uses only `ack_s`; raw `ack_async` never reaches FSM logic.
- States: IDLE, REQ_HI, ACK_LO, ABORT.
- IDLE:
  - `send`=1: latch `data_in` into `data_out`, go REQ_HI.
  - Otherwise stay in IDLE.
- REQ_HI: `req`=1.
  - `ack_s`=1: go ACK_LO.
- ACK_LO: `req`=0.
  - `ack_s`=0: pulse `done`, go IDLE.
- ABORT: `req`=0.
  - `ack_s`=0: go IDLE, with no `done`.
- `req` is a registered output, equal to 1 exactly while state is REQ_HI.
- `send` outside IDLE is ignored and not queued. `data_in` changes outside acceptance have no effect.
- `data_out` changes only at `send` acceptance or at reset.

## Timing
- `send` sampled high in IDLE at edge N: `req`=1 and `busy`=1 from edge N onward, i.e. visible in the cycle after N.
- `ack_async` rising before edge M: `ack_s`=1 after edge M+SYNC_STAGES−1. `req` falls at the following edge.
- Same latency for `ack_async` falling. `done` is high for the one cycle after `ack_s`=0 is seen in ACK_LO, and `busy`=0 in that same cycle.
- `send`=1 during the `done` cycle is accepted: FSM is in IDLE, so back-to-back transfers are allowed.
- Minimum transfer with an instant receiver is 2·SYNC_STAGES+2 cycles from `send` accepted to `done`.
- `ack_s` already 1 on entering REQ_HI (protocol violation): accepted as the acknowledge. This is not an error.

## Configuration
- `HS_TX_TIMEOUT_EN` defined:
  - A counter clears on entering REQ_HI or ACK_LO and increments each cycle spent in either state.
  - When it reaches TIMEOUT_CYCLES−1 with the exit condition unmet: pulse `err` for one cycle, force `req`=0, go ABORT.
  - ABORT then waits for `ack_s`=0 so a late acknowledge cannot corrupt the next transfer.
- `HS_TX_TIMEOUT_EN` undefined:
  - No counter and no ABORT state are generated. `err` is constant 0.
  - The FSM waits indefinitely.

## Test plan
All scenarios use WIDTH=8, SYNC_STAGES=2, TIMEOUT_CYCLES=16.
- Basic transfer: `data_in`=0xA5 with a one-cycle `send`. Receiver model raises `ack_async` 3 cycles after `req`, and drops it 3 cycles after `req` falls. Required: `data_out`=0xA5 from the `req` rising edge through `done`, exactly one `done` pulse, `busy` then 0.
- Ignored send: pulse `send` with `data_in`=0x3C while in REQ_HI. Required: `data_out` stays 0xA5, and only one `done` results.
- Back-to-back: assert `send` with `data_in`=0x0F during the `done` cycle. Required: `req` rises at the next edge with `data_out`=0x0F.
- Synchronous reset mid-transfer: `rst`=1 for one cycle while in ACK_LO with `ack_async`=1. Required: all outputs 0 after that edge, no `done`, `send` accepted once `rst`=0 and `ack_s`=0.
- Timeout, with the macro defined: `ack_async` held 0 after `send`. Required: `err` pulses once 16 cycles after entering REQ_HI, `req`=0, return to IDLE, no `done`.
- Timeout, with the macro undefined: same stimulus for 100 cycles. Required: `req` stays 1, `busy`=1, `err`=0.
